k423_if_bpu: RTL
================

// Module: k423_if_bpu
// PURPOSE
//  IF-stage branch predictor and EX-resolution receiver. Direct-mapped BTB with 2-bit
//  saturating counters supplies a next-PC prediction per fetch PC. Consumes EX-stage BJU
//  resolution (taken/target), detects mispredicts, drives redirect, trains the table.
// PARAMETERS
//  BTB_ENTRIES  16  number of BTB entries, power of 2; IDX_W = $clog2(BTB_ENTRIES)
//  TAG_W        8   tag bits taken from pc[IDX_W+2 +: TAG_W]
// PORTS
//  clk_i            in   1             core clock
//  rst_n_i          in   1             asynchronous active-low reset
//  flush_i          in   1             invalidate whole BTB (fence.i)
//  if_pc_i          in   CORE_ADDR_W   current fetch PC
//  if_pred_tkn_o    out  1             prediction: taken
//  if_pred_pc_o     out  CORE_ADDR_W   predicted next PC
//  ex_vld_i         in   1             EX holds a valid, non-stalled instruction this cycle
//  ex_pc_i          in   CORE_ADDR_W   PC of EX instruction
//  ex_is_bju_i      in   1             EX instruction is in the BJU group
//  ex_is_bxx_i      in   1             conditional branch (0 with is_bju = JAL/JALR)
//  ex_br_tkn_i      in   1             resolved taken (BJU output)
//  ex_br_pc_i       in   CORE_XLEN     resolved target (BJU output)
//  ex_pred_tkn_i    in   1             prediction made at fetch, piped to EX
//  ex_pred_pc_i     in   CORE_ADDR_W   predicted next PC, piped to EX
//  redirect_o       out  1             mispredict: flush younger stages, refetch
//  redirect_pc_o    out  CORE_ADDR_W   correct next PC
// BEHAVIOUR
//  Entry = {vld, jmp, tag[TAG_W], tgt[CORE_ADDR_W], cnt[2]}; idx = pc[IDX_W+1:2].
//  Reset (async): all vld=0, jmp=0, cnt=2'b01; tag/tgt don't-care. Outputs are
//   combinational: with table empty, if_pred_tkn_o=0, if_pred_pc_o=if_pc_i+4,
//   redirect_o=0 unless ex_vld_i.
//  Predict (0-cycle, combinational): hit = vld & tag match. pred_tkn = hit & (jmp | cnt[1]).
//   if_pred_pc_o = pred_tkn ? tgt : if_pc_i+4 (wraps mod 2^CORE_ADDR_W).
//  Redirect (combinational, same cycle as EX): correct_pc = (is_bju & br_tkn) ? br_pc & ~1
//   : ex_pc+4. redirect_o = ex_vld_i & (correct_pc != ex_pred_pc_i).
//   Non-BJU predicted taken (alias) -> redirect to ex_pc+4.
//  Update (registered, visible to predict next cycle), only when ex_vld_i:
//   - BJU hit: cnt sat-inc if tkn (cap 2'b11), sat-dec if not (floor 2'b00);
//     if tkn, tgt <= br_pc & ~1; jmp <= ~is_bxx.
//   - BJU miss & tkn: allocate (overwrite victim): vld=1, tag, tgt, jmp=~is_bxx, cnt=2'b10.
//   - BJU miss & not tkn: no write.
//   - Non-BJU hit: vld <= 0 (purge alias). Non-BJU miss: no write.
//  Same-cycle read/update of one index: predict sees old contents; no bypass.
//  flush_i: all vld <= 0 next edge; beats a coincident update (no allocate that cycle).
//   redirect_o still evaluated normally during flush.
//  Reset asserted mid-operation clears table immediately; no pending state survives.
//  Only one update per cycle; no internal stall; no handshake back-pressure.
// STRUCTURE
//  k423_defines.svh: BPU_CNT_W, BPU reset counter value (2'b01), allocate value (2'b10).
//  Sub-module k423_bpu_sat_cnt: 2-bit saturating inc/dec counter (en, up) -> next value.
//  Table held as flops (small BTB); one write port, one combinational read port.
// TESTING
//  Reset, if_pc=0x100 -> pred_tkn=0, pred_pc=0x104; redirect_o=0 with ex_vld_i=0.
//  BEQ @0x100 taken to 0x80 (pred 0x104) -> redirect_o=1, pc 0x80; next cycle
//   if_pc=0x100 -> pred_tkn=1, pred_pc=0x80 (cnt 2'b10).
//  Same BEQ not-taken x2 -> cnt 10->01->00; predicts 0x104; 3rd not-taken holds 00,
//   redirect_o=0 since pred matched.
//  JAL @0x200 ->0x400 allocated; then not-taken-cnt irrelevant: always predicts 0x400;
//   JALR target changes to 0x500 -> redirect to 0x500, tgt updated.
//  Alias: entry for 0x100 hit by non-BJU at 0x100 (pred 0x80) -> redirect to 0x104,
//   next cycle lookup 0x100 misses.
//  flush_i with coincident taken-miss update -> no entry allocated; all lookups miss;
//   async rst_n_i pulse mid-stream -> table empty immediately.

Source files
------------

// File: rtl/k423_if_bpu_pkg.sv
// Shared constants and types for the IF-stage branch predictor.
// Holds core address widths and the 2-bit confidence counter encodings
// used by the BTB and its saturating counter helper.
package k423_if_bpu_pkg;

    localparam int CORE_ADDR_W = 32;
    localparam int CORE_XLEN   = 32;

    // Confidence counter: MSB set means "predict taken".
    localparam int                   BPU_CNT_W     = 2;
    localparam logic [BPU_CNT_W-1:0] BPU_CNT_RST   = 2'b01;
    localparam logic [BPU_CNT_W-1:0] BPU_CNT_ALLOC = 2'b10;
    localparam logic [BPU_CNT_W-1:0] BPU_CNT_MAX   = 2'b11;

    typedef logic [CORE_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/k423_if_bpu_if.sv
// Fetch/execute bundle between the core pipeline and the branch predictor.
//   flush_i               : invalidate the whole BTB
//   if_pc_i               : fetch PC to predict for
//   if_pred_tkn_o/pc_o    : prediction back to fetch
//   ex_*_i                : EX-stage BJU resolution and the prediction it carried
//   redirect_o/pc_o       : mispredict redirect to the front end
// slave  = predictor side, master = pipeline side.
interface k423_if_bpu_if
    import k423_if_bpu_pkg::*;
();
    logic                   flush_i;
    addr_t                  if_pc_i;
    logic                   if_pred_tkn_o;
    addr_t                  if_pred_pc_o;
    logic                   ex_vld_i;
    addr_t                  ex_pc_i;
    logic                   ex_is_bju_i;
    logic                   ex_is_bxx_i;
    logic                   ex_br_tkn_i;
    logic [CORE_XLEN-1:0]   ex_br_pc_i;
    logic                   ex_pred_tkn_i;
    addr_t                  ex_pred_pc_i;
    logic                   redirect_o;
    addr_t                  redirect_pc_o;

    modport slave (
        input  flush_i, if_pc_i, ex_vld_i, ex_pc_i, ex_is_bju_i, ex_is_bxx_i,
               ex_br_tkn_i, ex_br_pc_i, ex_pred_tkn_i, ex_pred_pc_i,
        output if_pred_tkn_o, if_pred_pc_o, redirect_o, redirect_pc_o
    );

    modport master (
        output flush_i, if_pc_i, ex_vld_i, ex_pc_i, ex_is_bju_i, ex_is_bxx_i,
               ex_br_tkn_i, ex_br_pc_i, ex_pred_tkn_i, ex_pred_pc_i,
        input  if_pred_tkn_o, if_pred_pc_o, redirect_o, redirect_pc_o
    );

endinterface

// File: rtl/k423_if_bpu_sat_cnt.sv
// 2-bit saturating up/down counter, next-value logic only.
//   i_cnt : current value     i_en : apply a step
//   i_up  : 1 = increment     o_cnt: next value (saturates at 2'b11 / 2'b00)
module k423_if_bpu_sat_cnt
    import k423_if_bpu_pkg::*;
(
    input  logic [BPU_CNT_W-1:0] i_cnt,
    input  logic                 i_en,
    input  logic                 i_up,
    output logic [BPU_CNT_W-1:0] o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        if (i_en) begin
            if (i_up) begin
                if (i_cnt != BPU_CNT_MAX) o_cnt = i_cnt + BPU_CNT_W'(1);
            end else begin
                if (i_cnt != '0) o_cnt = i_cnt - BPU_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/k423_if_bpu.sv
// IF-stage branch predictor with EX-stage resolution.
// Direct-mapped BTB (flops) with 2-bit confidence counters gives a
// zero-cycle next-PC prediction for the fetch PC. The EX resolution is
// compared against the prediction carried down the pipe to raise a redirect,
// and the same resolution trains the table on the next clock edge.
//   clk_i   : core clock
//   rst_n_i : asynchronous active-low reset, empties the table
//   bpu     : fetch/EX bundle (slave side)
module k423_if_bpu
    import k423_if_bpu_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int TAG_W       = 8
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    k423_if_bpu_if.slave   bpu
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    logic [BTB_ENTRIES-1:0]                  r_vld;
    logic [BTB_ENTRIES-1:0]                  r_jmp;
    logic [BTB_ENTRIES-1:0][BPU_CNT_W-1:0]   r_cnt;
    logic [BTB_ENTRIES-1:0][TAG_W-1:0]       r_tag;
    logic [BTB_ENTRIES-1:0][CORE_ADDR_W-1:0] r_tgt;

    // ---------------- predict ----------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic             w_if_tkn;

    assign w_if_idx = bpu.if_pc_i[IDX_W+1:2];
    assign w_if_tag = bpu.if_pc_i[IDX_W+2 +: TAG_W];
    assign w_if_hit = r_vld[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
    // Unconditional jumps ignore the counter once they are in the table.
    assign w_if_tkn = w_if_hit & (r_jmp[w_if_idx] | r_cnt[w_if_idx][BPU_CNT_W-1]);

    assign bpu.if_pred_tkn_o = w_if_tkn;
    assign bpu.if_pred_pc_o  = w_if_tkn ? r_tgt[w_if_idx] : bpu.if_pc_i + CORE_ADDR_W'(4);

    // ---------------- resolve / redirect ----------------
    logic [IDX_W-1:0]   w_ex_idx;
    logic [TAG_W-1:0]   w_ex_tag;
    logic               w_ex_hit;
    addr_t              w_ex_tgt;
    addr_t              w_ex_correct;

    assign w_ex_idx = bpu.ex_pc_i[IDX_W+1:2];
    assign w_ex_tag = bpu.ex_pc_i[IDX_W+2 +: TAG_W];
    assign w_ex_hit = r_vld[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
    // JALR can produce an odd target; bit 0 is always dropped.
    assign w_ex_tgt = bpu.ex_br_pc_i[CORE_ADDR_W-1:0] & ~(CORE_ADDR_W'(1));

    // A non-BJU that was predicted taken (alias) falls into the pc+4 arm.
    assign w_ex_correct = (bpu.ex_is_bju_i & bpu.ex_br_tkn_i) ? w_ex_tgt
                                                                : bpu.ex_pc_i + CORE_ADDR_W'(4);

    assign bpu.redirect_o    = bpu.ex_vld_i & (w_ex_correct != bpu.ex_pred_pc_i);
    assign bpu.redirect_pc_o = w_ex_correct;

    // ---------------- train ----------------
    logic                 w_upd;
    logic                 w_bju_hit;
    logic                 w_alloc;
    logic                 w_purge;
    logic                 w_wr_tgt;
    logic [BPU_CNT_W-1:0] w_cnt_nxt;

    // Flush wins over any coincident update.
    assign w_upd     = bpu.ex_vld_i & ~bpu.flush_i;
    assign w_bju_hit = w_upd &  bpu.ex_is_bju_i &  w_ex_hit;
    assign w_alloc   = w_upd &  bpu.ex_is_bju_i & ~w_ex_hit & bpu.ex_br_tkn_i;
    assign w_purge   = w_upd & ~bpu.ex_is_bju_i &  w_ex_hit;
    assign w_wr_tgt  = w_upd &  bpu.ex_is_bju_i &  bpu.ex_br_tkn_i;

    k423_if_bpu_sat_cnt u_sat_cnt (
        .i_cnt (r_cnt[w_ex_idx]),
        .i_en  (w_bju_hit),
        .i_up  (bpu.ex_br_tkn_i),
        .o_cnt (w_cnt_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_vld <= '0;
            r_jmp <= '0;
            r_cnt <= {BTB_ENTRIES{BPU_CNT_RST}};
        end else if (bpu.flush_i) begin
            r_vld <= '0;
        end else begin
            if (w_bju_hit) begin
                r_cnt[w_ex_idx] <= w_cnt_nxt;
                r_jmp[w_ex_idx] <= ~bpu.ex_is_bxx_i;
            end
            if (w_alloc) begin
                r_vld[w_ex_idx] <= 1'b1;
                r_jmp[w_ex_idx] <= ~bpu.ex_is_bxx_i;
                r_cnt[w_ex_idx] <= BPU_CNT_ALLOC;
            end
            if (w_purge) begin
                r_vld[w_ex_idx] <= 1'b0;
            end
        end
    end

    // Tag/target payload is qualified by r_vld, so it needs no reset.
    // Rewriting the tag on a hit stores the same value, which keeps the enable simple.
    always_ff @(posedge clk_i) begin
        if (w_wr_tgt) begin
            r_tag[w_ex_idx] <= w_ex_tag;
            r_tgt[w_ex_idx] <= w_ex_tgt;
        end
    end

endmodule
